// File: rtl/secp256k1_inv_mod.sv
// Modular inverse a^(p-2) mod p on secp256k1 by left-to-right square-and-multiply over an external
// modular multiplier. Define SECP256K1_INV_MOD_ZERO_CHECK_EN to short-cut a == 0 with zero_err.
module secp256k1_inv_mod (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  output logic [255:0] result,
  output logic         done,
  output logic         busy,
  output logic         zero_err,
  output logic         mul_start,
  output logic [255:0] mul_a,
  output logic [255:0] mul_b,
  input  logic [255:0] mul_result,
  input  logic         mul_done
);

  localparam logic [255:0] EXP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQR_ISSUE = 3'd1,
    SQR_WAIT  = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t       state_r, state_s;
  logic [255:0] acc_r, acc_s;
  logic [255:0] base_r, base_s;
  logic [7:0]   idx_r, idx_s;
  logic [255:0] result_r, result_s;
  logic         done_r, done_s;
  logic         busy_r;
  logic         mul_start_r, mul_start_s;
  logic [255:0] mul_a_r, mul_a_s;
  logic [255:0] mul_b_r, mul_b_s;
  // zhold_r marks the extra FINISH cycle taken by the zero short-cut
  logic         zhold_r, zhold_s;
  logic         zero_skip_s;

`ifdef SECP256K1_INV_MOD_ZERO_CHECK_EN
  logic         zero_err_r;
  assign zero_skip_s = (a == 256'd0);
  assign zero_err    = zero_err_r;
`else
  assign zero_skip_s = 1'b0;
  assign zero_err    = 1'b0;
`endif

  assign result    = result_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

  // Next-state and next-output logic; outputs are registered from the values decided here
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    base_s      = base_r;
    idx_s       = idx_r;
    result_s    = result_r;
    done_s      = 1'b0;
    mul_start_s = 1'b0;
    mul_a_s     = mul_a_r;
    mul_b_s     = mul_b_r;
    zhold_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          base_s = a;
          acc_s  = a;
          idx_s  = 8'd254;
          if (zero_skip_s) begin
            state_s = FINISH;
            zhold_s = 1'b1;
          end else begin
            state_s     = SQR_ISSUE;
            mul_start_s = 1'b1;
            mul_a_s     = a;
            mul_b_s     = a;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SQR_ISSUE: begin
        state_s = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mul_done) begin
          acc_s = mul_result;
          if (EXP[idx_r]) begin
            state_s     = MUL_ISSUE;
            mul_start_s = 1'b1;
            mul_a_s     = mul_result;
            mul_b_s     = base_r;
          end else if (idx_r == 8'd0) begin
            state_s  = FINISH;
            done_s   = 1'b1;
            result_s = mul_result;
          end else begin
            idx_s       = idx_r - 8'd1;
            state_s     = SQR_ISSUE;
            mul_start_s = 1'b1;
            mul_a_s     = mul_result;
            mul_b_s     = mul_result;
          end
        end else begin
          state_s = SQR_WAIT;
        end
      end
      MUL_ISSUE: begin
        state_s = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done) begin
          acc_s = mul_result;
          if (idx_r == 8'd0) begin
            state_s  = FINISH;
            done_s   = 1'b1;
            result_s = mul_result;
          end else begin
            idx_s       = idx_r - 8'd1;
            state_s     = SQR_ISSUE;
            mul_start_s = 1'b1;
            mul_a_s     = mul_result;
            mul_b_s     = mul_result;
          end
        end else begin
          state_s = MUL_WAIT;
        end
      end
      FINISH: begin
        if (zhold_r) begin
          state_s  = FINISH;
          done_s   = 1'b1;
          result_s = 256'd0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 256'd0;
      base_r      <= 256'd0;
      idx_r       <= 8'd0;
      result_r    <= 256'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      mul_start_r <= 1'b0;
      mul_a_r     <= 256'd0;
      mul_b_r     <= 256'd0;
      zhold_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      base_r      <= base_s;
      idx_r       <= idx_s;
      result_r    <= result_s;
      done_r      <= done_s;
      busy_r      <= (state_s != IDLE);
      mul_start_r <= mul_start_s;
      mul_a_r     <= mul_a_s;
      mul_b_r     <= mul_b_s;
      zhold_r     <= zhold_s;
    end
  end

`ifdef SECP256K1_INV_MOD_ZERO_CHECK_EN
  // zero_err rises together with the done that closes the zero short-cut
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_err_r <= 1'b0;
    end else begin
      zero_err_r <= zhold_r;
    end
  end
`endif

endmodule

// File: tb/tb_secp256k1_inv_mod.sv
// Scoreboard bench for secp256k1_inv_mod: latency-programmable multiplier model, extended-Euclid
// reference inverse. Expectations follow SECP256K1_INV_MOD_ZERO_CHECK_EN when it is defined.
module tb_secp256k1_inv_mod;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] a = 256'd0;
  logic [255:0] result;
  logic         done, busy, zero_err, mul_start;
  logic [255:0] mul_a, mul_b;
  logic [255:0] mul_result = 256'd0;
  logic         mul_done = 1'b0;

  always #5 clk = ~clk;

  secp256k1_inv_mod dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .result(result), .done(done), .busy(busy),
    .zero_err(zero_err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  typedef struct {
    logic [255:0] a;
    logic [255:0] res;
    logic         zerr;
    int           lat;
    int           muls;
    int           start_cyc;
    int           muls0;
    int           stab0;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int lat = 1;
  int mul_total = 0;
  int stab_total = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] prod;
    prod = {256'd0, x} * {256'd0, y};
    return 256'(prod % {256'd0, P});
  endfunction

  // Extended Euclid keeping the Bezout coefficient reduced mod p
  function automatic logic [255:0] inv_ref(input logic [255:0] x);
    logic [255:0] r0, r1, t0, t1, q, rt;
    logic [256:0] s;
    if (x == 256'd0) return 256'd0;
    r0 = P; r1 = x; t0 = 256'd0; t1 = 256'd1;
    while (r1 != 256'd0) begin
      q  = r0 / r1;
      rt = r0 - q * r1;
      r0 = r1;
      r1 = rt;
      s  = {1'b0, t0} + {1'b0, P} - {1'b0, mulmod(q, t1)};
      t0 = t1;
      t1 = 256'(s % {1'b0, P});
    end
    return t0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done L cycles after the request, operands watched for stability meanwhile
  logic         pend = 1'b0;
  int           due = 0;
  logic [255:0] cap_a = 256'd0, cap_b = 256'd0;
  always @(negedge clk) begin
    if (pend && !rst && (mul_a !== cap_a || mul_b !== cap_b)) stab_total = stab_total + 1;
    if (pend && cyc == due) begin
      mul_done   = 1'b1;
      mul_result = mulmod(cap_a, cap_b);
      pend       = 1'b0;
    end else begin
      mul_done = 1'b0;
    end
    if (mul_start === 1'b1) begin
      pend      = 1'b1;
      due       = cyc + lat;
      cap_a     = mul_a;
      cap_b     = mul_b;
      mul_total = mul_total + 1;
    end
  end

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk256({tag, "_result"}, result, 256'd0);
    chkint({tag, "_done"}, int'(done), 0);
    chkint({tag, "_busy"}, int'(busy), 0);
    chkint({tag, "_zero_err"}, int'(zero_err), 0);
    chkint({tag, "_mul_start"}, int'(mul_start), 0);
    chk256({tag, "_mul_a"}, mul_a, 256'd0);
    chk256({tag, "_mul_b"}, mul_b, 256'd0);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles", budget);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Issue one inversion at a negedge; the monitor checks the response against the pushed entry
  task automatic run_op(input logic [255:0] x, input logic [255:0] exp_res, input int L,
                        input int repulse_at);
    exp_t e;
    lat         = L;
    e.a         = x;
    e.res       = exp_res;
`ifdef SECP256K1_INV_MOD_ZERO_CHECK_EN
    e.zerr = (x == 256'd0);
    e.lat  = (x == 256'd0) ? 2 : 1 + 503 * (L + 1);
    e.muls = (x == 256'd0) ? 0 : 503;
`else
    e.zerr = 1'b0;
    e.lat  = 1 + 503 * (L + 1);
    e.muls = 503;
`endif
    e.start_cyc = cyc;
    e.muls0     = mul_total;
    e.stab0     = stab_total;
    sb.push_back(e);
    a     = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    chkint("busy_after_start", int'(busy), 1);
    if (repulse_at > 0) begin
      repeat (repulse_at) @(negedge clk);
      a     = 256'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_empty(e.lat + 20);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: done=1 with no request outstanding, result %h", result);
            end else begin
              e = sb.pop_front();
              chk256("result", result, e.res);
              chkint("zero_err", int'(zero_err), int'(e.zerr));
              chkint("latency", cyc - e.start_cyc, e.lat);
              chkint("mul_count", mul_total - e.muls0, e.muls);
              chkint("operand_stability", stab_total - e.stab0, 0);
              if (e.a != 256'd0) chk256("inverse_identity", mulmod(e.a, result), 256'd1);
            end
          end
        end
      end
      begin : driver
        logic [255:0] half, x;
        int m0, n;
        half = 256'(({1'b0, P} + 257'd1) >> 1);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(256'd1, 256'd1, 1, 0);
        run_op(256'd2, half, 6, 0);
        repeat (5) @(negedge clk);
        chk256("result_hold", result, half);
        chkint("busy_idle", int'(busy), 0);
        run_op(256'd3, inv_ref(256'd3), 1, 10);
        run_op(P - 256'd1, P - 256'd1, 2, 0);
        run_op(256'd0, 256'd0, 1, 0);

        // Abort mid-run right after a request so its mul_done lands after reset is released
        lat   = 6;
        a     = 256'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        a     = 256'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (985) @(negedge clk);
        n = 0;
        while (mul_start !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        #1 rst = 1'b1;
        sb.delete();
        #1 chk_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        m0 = mul_total;
        repeat (20) @(negedge clk);
        chk_idle_outputs("after_abort");
        chkint("mul_count_after_abort", mul_total - m0, 0);

        run_op(256'd2, half, 1, 0);

        for (int i = 0; i < 30; i++) begin
          for (int w = 0; w < 8; w++) x[w*32 +: 32] = $urandom;
          if (x >= P) x = x - P;
          if (x == 256'd0) x = 256'd1;
          run_op(x, inv_ref(x), int'($urandom_range(1, 2)), 0);
        end
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
